kernel_scaler_seq: RTL and testbench

- Sequential, parametrised successor to the combinational 3x3 edge-kernel generator.
- On a start pulse, builds scaled Gx/Gy 3x3 kernels in sign-magnitude for one of three base operators (Sobel, Prewitt, Scharr).
- Uses one shared multiplier across 18 cycles and commits both kernels atomically to output registers.
- Sits between the brightness/config interface and the convolution datapath, which reads kx/ky while kernel_valid is high.

---
 rtl/kernel_scaler_seq.sv | 126 ++++++++++++
 tb/tb_kernel_scaler_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/kernel_scaler_seq.sv
// Sequential Gx/Gy 3x3 edge-kernel builder: one shared multiplier walks 18
// coefficients into a working buffer, then both kernels commit together.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; committed kernels held on kx/ky
// CALC   | one coefficient per cycle, idx 0-8 -> Gx, 9-17 -> Gy
// COMMIT | working buffer and sat bit copied to outputs in one edge
module kernel_scaler_seq #(
   parameter int MAG_W   = 4,
   parameter int SCALE_W = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   start,
   input  logic [SCALE_W-1:0]     bscalar,
   input  logic [1:0]             mode,
   input  logic                   scale_all,
   output logic                   busy,
   output logic                   kernel_valid,
   output logic [9*(MAG_W+1)-1:0] kx,
   output logic [9*(MAG_W+1)-1:0] ky,
   output logic                   sat_flag
);

   localparam int EW = MAG_W + 1;
   localparam int PW = (4 + SCALE_W > MAG_W) ? 4 + SCALE_W : MAG_W;
   localparam logic [PW-1:0] MAXV = PW'((64'd1 << MAG_W) - 64'd1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]         state;
   logic [4:0]         idx;
   logic [SCALE_W-1:0] bs_q;
   logic [1:0]         mode_q;
   logic               all_q;
   logic               wsat;
   logic [18*EW-1:0]   wbuf;

   logic               is_y;
   logic [4:0]         e;
   logic [1:0]         r, c, grow, gcol;
   logic [3:0]         mid_m, out_m, base_mag;
   logic               base_neg, scaled, sat;
   logic [PW-1:0]      prod;
   logic [MAG_W-1:0]   mag;
   logic [EW-1:0]      coef;

   always_comb begin
      is_y = (idx >= 5'd9);
      e    = is_y ? idx - 5'd9 : idx;
      if (e < 5'd3) begin
         r = 2'd0;
         c = e[1:0];
      end else if (e < 5'd6) begin
         r = 2'd1;
         c = 2'(e - 5'd3);
      end else begin
         r = 2'd2;
         c = 2'(e - 5'd6);
      end
      // Gy(r,c) is Gx(c,r), so Gy elements are looked up in the Gx table
      grow = is_y ? c : r;
      gcol = is_y ? r : c;
      case (mode_q)
         2'b01:   begin mid_m = 4'd1;  out_m = 4'd1; end
         2'b10:   begin mid_m = 4'd10; out_m = 4'd3; end
         default: begin mid_m = 4'd2;  out_m = 4'd1; end
      endcase
      base_mag = (gcol == 2'd1) ? 4'd0 : ((grow == 2'd1) ? mid_m : out_m);
      base_neg = (gcol == 2'd2);
      scaled   = all_q | (grow == 2'd1);
      prod     = scaled ? PW'(base_mag) * PW'(bs_q) : PW'(base_mag);
      sat      = (prod > MAXV);
      mag      = sat ? {MAG_W{1'b1}} : prod[MAG_W-1:0];
      coef     = {base_neg & (|mag), mag};
   end

   assign busy = (state == S_CALC) || (state == S_COMMIT);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         bs_q         <= '0;
         mode_q       <= '0;
         all_q        <= 1'b0;
         wsat         <= 1'b0;
         wbuf         <= '0;
         kx           <= '0;
         ky           <= '0;
         sat_flag     <= 1'b0;
         kernel_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  bs_q   <= bscalar;
                  mode_q <= mode;
                  all_q  <= scale_all;
                  idx    <= '0;
                  wsat   <= 1'b0;
                  state  <= S_CALC;
               end
            end
            S_CALC: begin
               wbuf[idx*EW +: EW] <= coef;
               if (sat) wsat <= 1'b1;
               if (idx == 5'd17) state <= S_COMMIT;
               else              idx   <= idx + 5'd1;
            end
            S_COMMIT: begin
               kx           <= wbuf[0 +: 9*EW];
               ky           <= wbuf[9*EW +: 9*EW];
               sat_flag     <= wsat;
               kernel_valid <= 1'b1;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_scaler_seq.sv
// Directed bench for kernel_scaler_seq with hand-computed 3x3 kernels.
module tb_kernel_scaler_seq;

   localparam int MAG_W = 4;
   localparam int SCALE_W = 4;
   localparam int EW = MAG_W + 1;
   localparam int KW = 9 * EW;

   typedef int arr9_t[9];

   logic               clk = 1'b0;
   logic               n_rst = 1'b0;
   logic               start = 1'b0;
   logic [SCALE_W-1:0] bscalar = '0;
   logic [1:0]         mode = '0;
   logic               scale_all = 1'b0;
   logic               busy, kernel_valid, sat_flag;
   logic [KW-1:0]      kx, ky;

   int n_chk = 0;
   int n_fail = 0;

   kernel_scaler_seq #(.MAG_W(MAG_W), .SCALE_W(SCALE_W)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .bscalar(bscalar),
      .mode(mode), .scale_all(scale_all), .busy(busy),
      .kernel_valid(kernel_valid), .kx(kx), .ky(ky), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [KW-1:0] pack9(input arr9_t v);
      logic [KW-1:0] p;
      int m;
      p = '0;
      for (int i = 0; i < 9; i++) begin
         m = (v[i] < 0) ? -v[i] : v[i];
         p[i*EW +: EW] = {(v[i] < 0), 4'(m)};
      end
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_valid"}, 64'(kernel_valid), 64'd0);
      chk({tag, "_kx"}, 64'(kx), 64'd0);
      chk({tag, "_ky"}, 64'(ky), 64'd0);
      chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
   endtask

   // start sampled at edge E; checks after each of E+1..E+19
   task automatic run(input string tag, input logic [1:0] m, input logic [3:0] b,
                      input logic sa, input logic [KW-1:0] ekx, input logic [KW-1:0] eky,
                      input logic esat, input logic [KW-1:0] okx, input logic [KW-1:0] oky,
                      input logic ovalid, input logic osat, input bit restart);
      @(negedge clk);
      mode = m; bscalar = b; scale_all = sa; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      mode = ~m; bscalar = ~b; scale_all = ~sa;
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk);
         #1;
         if (k < 19) begin
            chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
            chk({tag, "_valid_hold"}, 64'(kernel_valid), 64'(ovalid));
            chk({tag, "_kx_hold"}, 64'(kx), 64'(okx));
            chk({tag, "_ky_hold"}, 64'(ky), 64'(oky));
            chk({tag, "_sat_hold"}, 64'(sat_flag), 64'(osat));
         end
         if (restart && k == 5) start = 1'b1;
         if (restart && k == 6) start = 1'b0;
      end
      chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
      chk({tag, "_valid"}, 64'(kernel_valid), 64'd1);
      chk({tag, "_kx"}, 64'(kx), 64'(ekx));
      chk({tag, "_ky"}, 64'(ky), 64'(eky));
      chk({tag, "_sat"}, 64'(sat_flag), 64'(esat));
      if (restart) begin
         for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_no_requeue"}, 64'(busy), 64'd0);
         end
         chk({tag, "_kx_stable"}, 64'(kx), 64'(ekx));
      end
   endtask

   logic [KW-1:0] s3x, s3y, sc2x, sc2y, z, s1x, s1y, sc1x, sc1y, m3x, m3y;
   arr9_t a;

   initial begin
      a = '{1, 0, -1, 6, 0, -6, 1, 0, -1};    s3x  = pack9(a);
      a = '{1, 6, 1, 0, 0, 0, -1, -6, -1};    s3y  = pack9(a);
      a = '{6, 0, -6, 15, 0, -15, 6, 0, -6};  sc2x = pack9(a);
      a = '{6, 15, 6, 0, 0, 0, -6, -15, -6};  sc2y = pack9(a);
      z = '0;
      a = '{1, 0, -1, 2, 0, -2, 1, 0, -1};    s1x  = pack9(a);
      a = '{1, 2, 1, 0, 0, 0, -1, -2, -1};    s1y  = pack9(a);
      a = '{3, 0, -3, 10, 0, -10, 3, 0, -3};  sc1x = pack9(a);
      a = '{3, 10, 3, 0, 0, 0, -3, -10, -3};  sc1y = pack9(a);
      a = '{1, 0, -1, 4, 0, -4, 1, 0, -1};    m3x  = pack9(a);
      a = '{1, 4, 1, 0, 0, 0, -1, -4, -1};    m3y  = pack9(a);

      #12;
      check_zero("reset");
      @(negedge clk);
      n_rst = 1'b1;

      run("sobel_b3", 2'b00, 4'd3, 1'b0, s3x, s3y, 1'b0, z, z, 1'b0, 1'b0, 1'b0);
      chk("sobel_kx10", 64'(kx[3*EW +: EW]), 64'({1'b0, 4'd6}));
      chk("sobel_kx12", 64'(kx[5*EW +: EW]), 64'({1'b1, 4'd6}));
      run("scharr_b2", 2'b10, 4'd2, 1'b1, sc2x, sc2y, 1'b1, s3x, s3y, 1'b1, 1'b0, 1'b0);
      run("prewitt_b0", 2'b01, 4'd0, 1'b1, z, z, 1'b0, sc2x, sc2y, 1'b1, 1'b1, 1'b0);
      run("sobel_b1", 2'b00, 4'd1, 1'b0, s1x, s1y, 1'b0, z, z, 1'b1, 1'b0, 1'b0);
      run("atomic_scharr", 2'b10, 4'd1, 1'b0, sc1x, sc1y, 1'b0, s1x, s1y, 1'b1, 1'b0, 1'b1);

      // abort a build at CALC index 9
      @(negedge clk);
      mode = 2'b00; bscalar = 4'd3; scale_all = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("midop_busy_before", 64'(busy), 64'd1);
      n_rst = 1'b0;
      #1;
      check_zero("midop_reset");
      @(negedge clk);
      n_rst = 1'b1;
      run("mode11_b2", 2'b11, 4'd2, 1'b0, m3x, m3y, 1'b0, z, z, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
